// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding and default widths for the fetch front end.
package fetch_pkg;
    localparam int ADDR_W_DEF    = 32;
    localparam int INSTR_W_DEF   = 32;
    localparam int BUF_DEPTH_DEF = 2;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: first-word-fall-through FIFO with synchronous flush and occupancy count.
module fetch_buffer #(
    parameter int W     = 64,
    parameter int DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic                         valid,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic          push_ok, pop_ok;
    assign valid   = count != '0;
    assign dout    = valid ? mem[rd] : '0;
    assign push_ok = push & (count != CW'(DEPTH));
    assign pop_ok  = pop & valid;
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                mem[wr] <= din;
                wr      <= (wr == PW'(DEPTH - 1)) ? '0 : wr + 1'b1;
            end
            if (pop_ok)
                rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect/kill handling.
// Optional FETCH_STATS_EN adds saturating fetched/dropped counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               pc_enable_o,
    output logic               pc_load_o,
    output logic [ADDR_W-1:0]  pc_addr_o,
    input  logic               redirect_valid_i,
    input  logic [ADDR_W-1:0]  redirect_addr_i,
    output logic               imem_req_valid_o,
    input  logic               imem_req_ready_i,
    output logic [ADDR_W-1:0]  imem_req_addr_o,
    input  logic               imem_rsp_valid_i,
    input  logic [INSTR_W-1:0] imem_rsp_data_i,
    output logic               instr_valid_o,
    input  logic               instr_ready_i,
    output logic [INSTR_W-1:0] instr_data_o,
`ifdef FETCH_STATS_EN
    output logic [31:0]        stat_fetched_o,
    output logic [31:0]        stat_dropped_o,
`endif
    output logic [ADDR_W-1:0]  instr_pc_o
);
    state_t                        state, state_n;
    logic                          valid_n, kill, kill_n, push, drop, req_hs;
    logic [ADDR_W-1:0]             addr_n, req_pc, req_pc_n;
    logic [$clog2(BUF_DEPTH+1)-1:0] count;
    assign req_hs      = imem_req_valid_o & imem_req_ready_i;
    assign pc_load_o   = rst_n & redirect_valid_i;
    assign pc_addr_o   = redirect_addr_i;
    assign pc_enable_o = rst_n & (redirect_valid_i | (req_hs & ~kill));
    always_comb begin
        state_n  = state;
        valid_n  = imem_req_valid_o;
        addr_n   = imem_req_addr_o;
        req_pc_n = req_pc;
        kill_n   = kill;
        push     = 1'b0;
        drop     = 1'b0;
        case (state)
            IDLE: begin
                kill_n = 1'b0;
                if (!redirect_valid_i && int'(count) < BUF_DEPTH) begin
                    valid_n  = 1'b1;
                    addr_n   = pc_i;
                    req_pc_n = pc_i;
                    state_n  = REQ;
                end
            end
            REQ: begin
                kill_n = kill | redirect_valid_i;
                if (req_hs) begin
                    valid_n = 1'b0;
                    state_n = (kill | redirect_valid_i) ? DROP : WAIT;
                end
            end
            WAIT: begin
                push    = imem_rsp_valid_i & ~redirect_valid_i;
                drop    = imem_rsp_valid_i & redirect_valid_i;
                state_n = imem_rsp_valid_i ? IDLE : redirect_valid_i ? DROP : WAIT;
            end
            default: begin
                drop    = imem_rsp_valid_i;
                kill_n  = imem_rsp_valid_i ? 1'b0 : kill;
                state_n = imem_rsp_valid_i ? IDLE : DROP;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            imem_req_valid_o <= 1'b0;
            imem_req_addr_o  <= '0;
            req_pc           <= '0;
            kill             <= 1'b0;
        end else begin
            state            <= state_n;
            imem_req_valid_o <= valid_n;
            imem_req_addr_o  <= addr_n;
            req_pc           <= req_pc_n;
            kill             <= kill_n;
        end
    end
    fetch_buffer #(.W(ADDR_W + INSTR_W), .DEPTH(BUF_DEPTH)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid_i),
        .push  (push),
        .din   ({req_pc, imem_rsp_data_i}),
        .pop   (instr_ready_i),
        .valid (instr_valid_o),
        .dout  ({instr_pc_o, instr_data_o}),
        .count (count)
    );
`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_fetched_o <= '0;
            stat_dropped_o <= '0;
        end else begin
            if (push && stat_fetched_o != '1)
                stat_fetched_o <= stat_fetched_o + 1'b1;
            if (drop && stat_dropped_o != '1)
                stat_dropped_o <= stat_dropped_o + 1'b1;
        end
    end
`endif
endmodule
